ps2_keycode_rx: RTL

//  Producer end of the 8-bit keycode bus consumed by the ball motion logic.

---
 rtl/ps2_keycode_rx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 keyboard receiver: deserialises frames, tracks E0/F0 prefixes, and holds the HID usage of a pressed movement key.
// Outputs are registered one cycle after the detected stop-bit fall; the PS/2 device cannot be back-pressured.
module ps2_keycode_rx #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] keycode_o,
  output logic       key_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_strobe_o,
  output logic       frame_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          to_q, to_d;
  logic                   brk_q, brk_d, ext_q, ext_d;
  logic [7:0]             keycode_q, keycode_d, rx_byte_q, rx_byte_d;
  logic                   key_valid_q, key_valid_d, rx_strobe_q, rx_strobe_d, err_q, err_d;
  logic                   fall, bit_in, timeout;
  logic [7:0]             mapped;

  function automatic logic [7:0] map_key(input logic ext, input logic [7:0] code);
    logic [7:0] usage;
    usage = 8'h00;
    if (!ext) begin
      case (code)
        8'h1D:   usage = 8'h1A;
        8'h1C:   usage = 8'h04;
        8'h1B:   usage = 8'h16;
        8'h23:   usage = 8'h07;
        8'h29:   usage = 8'h2C;
        default: usage = 8'h00;
      endcase
    end else begin
      case (code)
        8'h75:   usage = 8'h52;
        8'h72:   usage = 8'h51;
        8'h6B:   usage = 8'h50;
        8'h74:   usage = 8'h4F;
        default: usage = 8'h00;
      endcase
    end
    return usage;
  endfunction

  assign fall    = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign bit_in  = dat_sync_q[SYNC_STAGES-1];
  assign timeout = (state_q != IDLE) && (to_q == TW'(TIMEOUT_CYCLES - 1));
  assign mapped  = map_key(ext_q, shift_q);

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    to_d        = to_q + 1'b1;
    brk_d       = brk_q;
    ext_d       = ext_q;
    keycode_d   = keycode_q;
    rx_byte_d   = rx_byte_q;
    rx_strobe_d = 1'b0;
    err_d       = 1'b0;
    if (state_q == IDLE || fall) to_d = '0;
    // A timeout takes priority over a coincident fall, which is dropped.
    if (timeout) begin
      err_d   = 1'b1;
      state_d = IDLE;
      brk_d   = 1'b0;
      ext_d   = 1'b0;
      to_d    = '0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!bit_in) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
          end
        end
        DATA: begin
          shift_d  = {bit_in, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = bit_in;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (bit_in && (^{shift_q, par_q})) begin
            rx_strobe_d = 1'b1;
            rx_byte_d   = shift_q;
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              brk_d = 1'b0;
              ext_d = 1'b0;
              if (mapped != 8'h00) begin
                if (!brk_q) keycode_d = mapped;
                else if (mapped == keycode_q) keycode_d = 8'h00;
              end
            end
          end else begin
            err_d = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    key_valid_d = (keycode_d != keycode_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      clk_prev_q  <= 1'b1;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      to_q        <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      keycode_q   <= 8'h00;
      rx_byte_q   <= 8'h00;
      key_valid_q <= 1'b0;
      rx_strobe_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_q        <= to_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      keycode_q   <= keycode_d;
      rx_byte_q   <= rx_byte_d;
      key_valid_q <= key_valid_d;
      rx_strobe_q <= rx_strobe_d;
      err_q       <= err_d;
    end
  end

  assign keycode_o   = keycode_q;
  assign key_valid_o = key_valid_q;
  assign rx_byte_o   = rx_byte_q;
  assign rx_strobe_o = rx_strobe_q;
  assign frame_err_o = err_q;

endmodule
